// File: rtl/colormap_ctrl.sv
// colormap_ctrl: converts an 8-bit pixel stream to 24-bit RGB using one of
// three maps (gray, inverted gray, palette lookup). The palette lives in two
// 256x24 banks. The host writes the shadow bank. A commit stages a new map
// and swaps banks on the next start-of-frame pixel, so a frame never mixes
// palettes.
//
// Ports
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_valid/o_ready           input pixel handshake; i_pixel, i_sof, i_eol
//   o_valid/i_ready           output handshake; o_r, o_g, o_b, o_sof, o_eol
//   i_wr_stb/addr/data        shadow palette write ({R,G,B})
//   i_map_sel, i_commit       map to stage, and the request to swap on next SOF
//   o_wr_err                  one-cycle pulse: a write was dropped while pending
//   o_pending, o_map, o_bank  swap pending, active map, active bank
module colormap_ctrl #(
   parameter logic [1:0] DEFAULT_MAP = 2'd0
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [7:0]  i_pixel,
   input  logic        i_sof,
   input  logic        i_eol,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [7:0]  o_r,
   output logic [7:0]  o_g,
   output logic [7:0]  o_b,
   output logic        o_sof,
   output logic        o_eol,
   input  logic        i_wr_stb,
   input  logic [7:0]  i_wr_addr,
   input  logic [23:0] i_wr_data,
   input  logic [1:0]  i_map_sel,
   input  logic        i_commit,
   output logic        o_wr_err,
   output logic        o_pending,
   output logic [1:0]  o_map,
   output logic        o_bank
);

   typedef enum logic {ST_RUN = 1'b0, ST_PEND = 1'b1} state_t;

   state_t      state_q, state_d;
   logic        bank_q, bank_d;
   logic [1:0]  map_q, map_d;
   logic [1:0]  stg_q, stg_d;
   logic [1:0]  map_new;
   logic        wr_err_q, wr_err_d;
   logic        ce, in_hs, sof_hs, swap, wr_en;

   // Two banks stacked in one array; the bank bit is the address MSB.
   logic [23:0] pal_mem [0:511];

   logic        vld_p1_q, vld_p1_d;
   logic        sof_p1_q, eol_p1_q;
   logic [7:0]  pix_p1_q;
   logic [1:0]  map_p1_q;
   logic [23:0] pal_p1_q;

   logic        vld_p2_q, vld_p2_d;
   logic        sof_p2_q, sof_p2_d;
   logic        eol_p2_q, eol_p2_d;
   logic [23:0] rgb_p2_q, rgb_p2_d;

   function automatic logic [23:0] color_map(input logic [1:0]  map,
                                             input logic [7:0]  pix,
                                             input logic [23:0] pal);
      case (map)
         2'd1:    color_map = {3{~pix}};
         2'd2:    color_map = pal;
         default: color_map = {3{pix}};
      endcase
   endfunction

   // Control: handshake, commit/swap FSM, host write gating
   always_comb begin
      ce       = !vld_p2_q || i_ready;
      in_hs    = i_valid && ce;
      sof_hs   = in_hs && i_sof;
      state_d  = state_q;
      stg_d    = stg_q;
      map_new  = map_q;
      swap     = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (i_commit) begin
               stg_d = i_map_sel;
               // A commit that coincides with an SOF handshake swaps at once.
               if (sof_hs) begin
                  swap    = 1'b1;
                  map_new = i_map_sel;
               end else begin
                  state_d = ST_PEND;
               end
            end
         end
         ST_PEND: begin
            if (sof_hs) begin
               swap    = 1'b1;
               map_new = stg_q;
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
      // bank_d/map_d also select the bank/map for the pixel accepted now,
      // so the SOF pixel that triggers a swap already sees the new palette.
      bank_d   = swap ? !bank_q : bank_q;
      map_d    = swap ? map_new : map_q;
      wr_en    = i_wr_stb && (state_q == ST_RUN);
      wr_err_d = i_wr_stb && (state_q == ST_PEND);
      vld_p1_d = ce ? i_valid : vld_p1_q;
      vld_p2_d = ce ? vld_p1_q : vld_p2_q;
      sof_p2_d = ce ? sof_p1_q : sof_p2_q;
      eol_p2_d = ce ? eol_p1_q : eol_p2_q;
      rgb_p2_d = ce ? color_map(map_p1_q, pix_p1_q, pal_p1_q) : rgb_p2_q;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q  <= ST_RUN;
         bank_q   <= 1'b0;
         map_q    <= DEFAULT_MAP;
         stg_q    <= DEFAULT_MAP;
         wr_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         bank_q   <= bank_d;
         map_q    <= map_d;
         stg_q    <= stg_d;
         wr_err_q <= wr_err_d;
      end
   end

   // Palette RAM: not reset. Writes always target the shadow bank.
   always_ff @(posedge i_clk) begin
      if (wr_en) pal_mem[{!bank_q, i_wr_addr}] <= i_wr_data;
   end

   // Stage 1: synchronous palette read plus per-pixel map capture
   always_ff @(posedge i_clk) begin
      if (ce) begin
         pix_p1_q <= i_pixel;
         map_p1_q <= map_d;
         pal_p1_q <= pal_mem[{bank_d, i_pixel}];
         sof_p1_q <= i_sof && i_valid;
         eol_p1_q <= i_eol && i_valid;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) vld_p1_q <= 1'b0;
      else            vld_p1_q <= vld_p1_d;
   end

   // Stage 2: colour conversion into the output register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         vld_p2_q <= 1'b0;
         sof_p2_q <= 1'b0;
         eol_p2_q <= 1'b0;
         rgb_p2_q <= 24'd0;
      end else begin
         vld_p2_q <= vld_p2_d;
         sof_p2_q <= sof_p2_d;
         eol_p2_q <= eol_p2_d;
         rgb_p2_q <= rgb_p2_d;
      end
   end

   assign o_ready   = ce;
   assign o_valid   = vld_p2_q;
   assign o_r       = rgb_p2_q[23:16];
   assign o_g       = rgb_p2_q[15:8];
   assign o_b       = rgb_p2_q[7:0];
   assign o_sof     = sof_p2_q;
   assign o_eol     = eol_p2_q;
   assign o_wr_err  = wr_err_q;
   assign o_pending = (state_q == ST_PEND);
   assign o_map     = map_q;
   assign o_bank    = bank_q;

endmodule

// File: tb/tb_colormap_ctrl.sv
`timescale 1ns/1ps
module tb_colormap_ctrl;
   localparam logic [1:0] DM = 2'd0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic i_valid = 1'b0, i_sof = 1'b0, i_eol = 1'b0, i_ready = 1'b1;
   logic [7:0] i_pixel = 8'd0;
   logic i_wr_stb = 1'b0, i_commit = 1'b0;
   logic [7:0] i_wr_addr = 8'd0;
   logic [23:0] i_wr_data = 24'd0;
   logic [1:0] i_map_sel = 2'd0;
   logic o_ready, o_valid, o_sof, o_eol, o_wr_err, o_pending, o_bank;
   logic [7:0] o_r, o_g, o_b;
   logic [1:0] o_map;

   int checks = 0, errors = 0, cyc_cnt = 0;

   colormap_ctrl #(.DEFAULT_MAP(DM)) dut (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_valid(i_valid), .o_ready(o_ready), .i_pixel(i_pixel), .i_sof(i_sof), .i_eol(i_eol),
      .o_valid(o_valid), .i_ready(i_ready), .o_r(o_r), .o_g(o_g), .o_b(o_b),
      .o_sof(o_sof), .o_eol(o_eol),
      .i_wr_stb(i_wr_stb), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
      .i_map_sel(i_map_sel), .i_commit(i_commit),
      .o_wr_err(o_wr_err), .o_pending(o_pending), .o_map(o_map), .o_bank(o_bank)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Reference model state
   logic [23:0] pal_m [2][256];
   bit          known_m [2][256];
   bit          bank_m = 1'b0, pend_m = 1'b0, err_m = 1'b0;
   logic [1:0]  map_m = DM, stg_m = DM;
   bit          lat_mode = 1'b0, hs_last = 1'b0;

   typedef struct {
      logic [23:0] rgb;
      bit sof;
      bit eol;
      bit dc;
      bit lat;
      int acc;
   } exp_t;
   exp_t sbq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] ref_color(input logic [1:0] m, input bit b, input logic [7:0] p);
      logic [7:0] v;
      if (m == 2'd2) return pal_m[b][p];
      if (m == 2'd1) v = 8'(255 - int'(p));
      else v = p;
      return {v, v, v};
   endfunction

   // Applies one clock edge worth of spec behaviour to the model.
   task automatic model_step(input bit hs);
      bit do_swap = 1'b0;
      bit old_bank = bank_m;
      logic [1:0] nm = map_m;
      exp_t e;
      err_m = i_wr_stb && pend_m;
      if (!pend_m && i_commit) begin
         stg_m = i_map_sel;
         if (hs && i_sof) begin do_swap = 1'b1; nm = i_map_sel; end
         else pend_m = 1'b1;
      end else if (pend_m && hs && i_sof) begin
         do_swap = 1'b1; nm = stg_m; pend_m = 1'b0;
      end
      if (do_swap) begin bank_m = !bank_m; map_m = nm; end
      if (hs) begin
         e.rgb = ref_color(map_m, bank_m, i_pixel);
         e.dc  = (map_m == 2'd2) && !known_m[bank_m][i_pixel];
         e.sof = i_sof; e.eol = i_eol; e.lat = lat_mode; e.acc = cyc_cnt;
         sbq.push_back(e);
      end
      if (i_wr_stb && !err_m) begin
         pal_m[!old_bank][i_wr_addr] = i_wr_data;
         known_m[!old_bank][i_wr_addr] = 1'b1;
      end
   endtask

   // Called at negedge+1; returns at the next negedge+1.
   task automatic cyc();
      #1;
      hs_last = i_valid && o_ready;
      model_step(hs_last);
      @(negedge clk);
      if (rst_n) begin
         chk("pending", 32'(o_pending), 32'(pend_m));
         chk("bank", 32'(o_bank), 32'(bank_m));
         chk("map", 32'(o_map), 32'(map_m));
         chk("wr_err", 32'(o_wr_err), 32'(err_m));
      end
      i_wr_stb = 1'b0;
      i_commit = 1'b0;
      #1;
   endtask

   task automatic send_pix(input logic [7:0] p, input bit s, input bit e);
      bit ok = 1'b0;
      i_valid = 1'b1; i_pixel = p; i_sof = s; i_eol = e;
      for (int k = 0; k < 40 && !ok; k++) begin
         cyc();
         ok = hs_last;
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      i_valid = 1'b0; i_sof = 1'b0; i_eol = 1'b0;
      for (int k = 0; k < n; k++) cyc();
   endtask

   task automatic fill_shadow();
      i_valid = 1'b0;
      for (int a = 0; a < 256; a++) begin
         i_wr_stb = 1'b1; i_wr_addr = 8'(a); i_wr_data = 24'($urandom);
         cyc();
      end
   endtask

   // Output monitor: checks each transfer against the scoreboard head.
   exp_t me;
   always begin
      @(negedge clk);
      #3;
      if (rst_n && o_valid && i_ready) begin
         if (sbq.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
         else begin
            me = sbq.pop_front();
            if (!me.dc) chk("rgb", 32'({o_r, o_g, o_b}), 32'(me.rgb));
            chk("sof", 32'(o_sof), 32'(me.sof));
            chk("eol", 32'(o_eol), 32'(me.eol));
            if (me.lat) chk("latency", 32'(cyc_cnt - me.acc), 32'd2);
         end
      end
   end

   logic [7:0]  px [3];
   logic [25:0] held;
   bit          have;
   int          idx;

   initial begin
      // Reset state
      #2;
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_rgb", 32'({o_r, o_g, o_b}), 32'd0);
      chk("rst_sofeol", 32'({o_sof, o_eol}), 32'd0);
      chk("rst_err", 32'(o_wr_err), 32'd0);
      chk("rst_pending", 32'(o_pending), 32'd0);
      chk("rst_bank", 32'(o_bank), 32'd0);
      chk("rst_map", 32'(o_map), 32'(DM));
      @(negedge clk); #1;
      rst_n = 1'b1;
      chk("ready_after_reset", 32'(o_ready), 32'd1);
      idle(2);

      // Gray map, back-to-back, fixed latency
      lat_mode = 1'b1;
      send_pix(8'h00, 1, 0);
      send_pix(8'h7F, 0, 0);
      send_pix(8'hFF, 0, 1);
      lat_mode = 1'b0;
      idle(4);

      // Shadow write, commit map 2 mid-frame, swap on next SOF
      send_pix(8'h01, 1, 0);
      i_wr_stb = 1'b1; i_wr_addr = 8'h10; i_wr_data = 24'h123456;
      send_pix(8'h02, 0, 0);
      i_commit = 1'b1; i_map_sel = 2'd2;
      send_pix(8'h03, 0, 0);
      send_pix(8'h04, 0, 0);
      send_pix(8'h05, 0, 1);
      idle(2);
      chk("pend_before_sof", 32'(o_pending), 32'd1);
      send_pix(8'h10, 1, 0);
      chk("bank_after_swap", 32'(o_bank), 32'd1);
      idle(3);

      // Write dropped while pending
      i_wr_stb = 1'b1; i_wr_addr = 8'h10; i_wr_data = 24'h654321;
      cyc();
      i_commit = 1'b1; i_map_sel = 2'd2;
      cyc();
      i_wr_stb = 1'b1; i_wr_addr = 8'h10; i_wr_data = 24'hABCDEF;
      cyc();
      chk("wr_err_pulse", 32'(o_wr_err), 32'd1);
      cyc();
      chk("wr_err_gone", 32'(o_wr_err), 32'd0);
      send_pix(8'h10, 1, 1);
      idle(3);

      // Commit coincident with SOF: immediate swap
      i_commit = 1'b1; i_map_sel = 2'd1;
      send_pix(8'h20, 1, 0);
      chk("no_pend_immediate", 32'(o_pending), 32'd0);
      send_pix(8'h21, 0, 1);
      idle(3);

      // Backpressure: i_ready low for 5 cycles with 3 pixels offered
      px[0] = 8'h30; px[1] = 8'h31; px[2] = 8'h32;
      i_ready = 1'b0; idx = 0; have = 1'b0;
      i_valid = 1'b1; i_pixel = px[0]; i_sof = 1'b1; i_eol = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc();
         if (hs_last) begin
            idx++;
            if (idx < 3) begin i_pixel = px[idx]; i_sof = 1'b0; i_eol = (idx == 2); end
            else i_valid = 1'b0;
         end
         if (o_valid) begin
            chk("stall_ready", 32'(o_ready), 32'd0);
            if (!have) begin held = {o_sof, o_eol, o_r, o_g, o_b}; have = 1'b1; end
            else chk("stall_hold", 32'({o_sof, o_eol, o_r, o_g, o_b}), 32'(held));
         end
      end
      chk("stall_seen", 32'(have), 32'd1);
      i_ready = 1'b1;
      while (idx < 3) begin
         send_pix(px[idx], idx == 0, idx == 2);
         idx++;
      end
      idle(4);

      // Reset while pending with pixels in flight
      i_commit = 1'b1; i_map_sel = 2'd2;
      send_pix(8'h40, 0, 0);
      send_pix(8'h41, 0, 0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst2_valid", 32'(o_valid), 32'd0);
      chk("rst2_bank", 32'(o_bank), 32'd0);
      chk("rst2_map", 32'(o_map), 32'(DM));
      chk("rst2_pending", 32'(o_pending), 32'd0);
      sbq.delete();
      bank_m = 1'b0; map_m = DM; stg_m = DM; pend_m = 1'b0; err_m = 1'b0;
      i_valid = 1'b0;
      @(negedge clk); #1;
      rst_n = 1'b1;
      chk("ready_after_reset2", 32'(o_ready), 32'd1);
      idle(2);

      // Populate both banks, then randomized traffic
      fill_shadow();
      i_commit = 1'b1; i_map_sel = 2'd2;
      send_pix(8'h00, 1, 0);
      fill_shadow();
      for (int n = 0; n < 400; n++) begin
         i_ready   = ($urandom_range(3) != 0);
         i_valid   = 1'($urandom_range(1));
         i_pixel   = 8'($urandom);
         i_sof     = ($urandom_range(15) == 0);
         i_eol     = ($urandom_range(7) == 0);
         i_wr_stb  = ($urandom_range(7) == 0);
         i_wr_addr = 8'($urandom);
         i_wr_data = 24'($urandom);
         i_commit  = ($urandom_range(15) == 0);
         i_map_sel = 2'($urandom_range(3));
         cyc();
      end
      i_ready = 1'b1;
      i_valid = 1'b0;
      for (int k = 0; k < 20 && sbq.size() != 0; k++) cyc();
      idle(2);
      chk("drain", 32'(sbq.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/colormap_ctrl.md
COLORMAP_CTRL -- requirements
Module: colormap_ctrl

Interface
REQ-001 SHALL have parameter DEFAULT_MAP, default 2'd0, meaning the map selected out of reset (0 gray, 1 inverted gray, 2 palette).
REQ-002 SHALL have ports: i_clk  in  1  rising-edge clock; i_reset_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have pixel input ports: i_valid in 1; o_ready out 1; i_pixel in 8; i_sof in 1 (first pixel of frame); i_eol in 1 (last pixel of line).
REQ-004 SHALL have pixel output ports: o_valid out 1; i_ready in 1; o_r, o_g, o_b out 8 each; o_sof out 1; o_eol out 1.
REQ-005 SHALL have host ports: i_wr_stb in 1; i_wr_addr in 8; i_wr_data in 24 ({R,G,B}); i_map_sel in 2; i_commit in 1; o_wr_err out 1; o_pending out 1; o_map out 2; o_bank out 1.

Function
REQ-006 SHALL hold two 256x24 palette banks; o_bank names the active (read) bank, the other is the shadow bank.
REQ-007 SHALL write i_wr_data to shadow[i_wr_addr] on any cycle with i_wr_stb=1 and o_pending=0.
REQ-008 SHALL drop a write with i_wr_stb=1 while o_pending=1 and pulse o_wr_err high for exactly the following cycle.
REQ-009 SHALL implement states RUN and PEND; o_pending=1 only in PEND.
REQ-010 SHALL, in RUN on i_commit=1, latch i_map_sel into a staged map register and go to PEND; i_commit in PEND is ignored.
REQ-011 SHALL, in PEND, on the input handshake (i_valid & o_ready) of a pixel with i_sof=1, toggle o_bank, load o_map from the staged map, return to RUN; that SOF pixel uses the new bank/map.
REQ-012 SHALL treat i_commit=1 in RUN in the same cycle as an SOF handshake as an immediate swap for that pixel (no PEND cycle).
REQ-013 SHALL map pixel p: map 0 -> R=G=B=p; map 1 -> R=G=B=255-p; map 2 -> active[p]; map 3 -> identical to map 0.
REQ-014 SHALL be a two-stage pipeline (stage 1 palette read/register, stage 2 output register) carrying valid, sof, eol alongside data.
REQ-015 SHALL advance all stages when ce = !o_valid | i_ready; o_ready = ce.
REQ-016 SHALL deliver a pixel accepted in cycle N at o_valid in cycle N+2 when i_ready stays 1, sustaining one pixel per cycle.
REQ-017 SHALL hold o_r, o_g, o_b, o_sof, o_eol, o_valid stable while o_valid=1 and i_ready=0.
REQ-018 SHALL capture bank and map per pixel at acceptance so a swap never alters pixels already in the pipeline.
REQ-019 SHALL not order host writes with the stream; shadow writes never affect active-bank reads.

Reset
REQ-020 SHALL, while i_reset_n=0, force o_valid=0, o_r=o_g=o_b=0, o_sof=o_eol=0, o_wr_err=0, o_pending=0 (RUN), o_bank=0, o_map=DEFAULT_MAP, staged map=DEFAULT_MAP, and discard pipeline contents.
REQ-021 SHALL leave palette RAM contents unaffected by reset (uninitialised after power-up).
REQ-022 SHALL drive o_ready=1 in the first cycle after i_reset_n deasserts.

Verification
REQ-023 Reset, map 0, i_ready=1, pixels 0x00,0x7F,0xFF streamed back-to-back -> outputs 000000,7F7F7F,FFFFFF, each 2 cycles after acceptance, no gaps.
REQ-024 Write shadow[0x10]=0x123456, commit map 2 mid-frame, stream rest of frame then SOF pixel 0x10 -> pre-SOF pixels stay gray; SOF pixel outputs R=12,G=34,B=56; o_bank=1; o_pending 1 until that handshake.
REQ-025 i_wr_stb while o_pending=1 -> write dropped (shadow value unchanged after later swap), o_wr_err high exactly one cycle.
REQ-026 i_commit map 1 in same cycle as SOF pixel 0x20 in RUN -> that pixel outputs DFDFDF; o_pending never asserts.
REQ-027 Hold i_ready=0 for 5 cycles with 3 pixels offered -> o_ready=0 once pipeline full, outputs stable, no loss/duplication; order preserved after release.
REQ-028 Assert i_reset_n=0 during PEND with pixels in flight -> o_valid=0 immediately, o_bank=0, o_map=DEFAULT_MAP, o_pending=0.
